// File: rtl/extrema_tracker.sv
// Running max/min tracker over a valid/ready sample packet, time-sharing one external
// magnitude comparator; results are held in DONE until the downstream handshake.
module extrema_tracker #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     in_data_i,
    input  logic             in_last_i,
    output logic [W-1:0]     cmp_a_o,
    output logic [W-1:0]     cmp_b_o,
    input  logic             cmp_gt_i,
    input  logic             cmp_eq_i,
    input  logic             cmp_lt_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     out_max_o,
    output logic [W-1:0]     out_min_o,
    output logic [CNT_W-1:0] out_count_o,
    output logic             out_err_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CMP_MAX = 2'd1,
        S_CMP_MIN = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A healthy comparator asserts exactly one of its three result flags.
    function automatic logic flags_onehot(input logic gt, input logic eq, input logic lt);
        case ({gt, eq, lt})
            3'b100, 3'b010, 3'b001: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    state_e           state_q, state_d;
    logic [W-1:0]     max_q, max_d, min_q, min_d, sample_q, sample_d;
    logic [W-1:0]     cmp_a_q, cmp_a_d, cmp_b_q, cmp_b_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             last_q, last_d, err_q, err_d;
    logic             flags_ok_s;

    assign flags_ok_s = flags_onehot(cmp_gt_i, cmp_eq_i, cmp_lt_i);

    // Next-state logic; comparator operands are registered one state ahead of use.
    always_comb begin
        state_d  = state_q;
        max_d    = max_q;
        min_d    = min_q;
        sample_d = sample_q;
        last_d   = last_q;
        count_d  = count_q;
        err_d    = err_q;
        cmp_a_d  = {W{1'b0}};
        cmp_b_d  = {W{1'b0}};
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    if (count_q == {CNT_W{1'b0}}) begin
                        max_d   = in_data_i;
                        min_d   = in_data_i;
                        count_d = CNT_ONE;
                        err_d   = 1'b0;
                        state_d = in_last_i ? S_DONE : S_IDLE;
                    end else begin
                        sample_d = in_data_i;
                        last_d   = in_last_i;
                        cmp_a_d  = in_data_i;
                        cmp_b_d  = max_q;
                        state_d  = S_CMP_MAX;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMP_MAX: begin
                if (!flags_ok_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (cmp_gt_i) begin
                    max_d = sample_q;
                end else begin
                    max_d = max_q;
                end
                cmp_a_d = sample_q;
                cmp_b_d = min_q;
                state_d = S_CMP_MIN;
            end
            S_CMP_MIN: begin
                if (!flags_ok_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (cmp_lt_i) begin
                    min_d = sample_q;
                end else begin
                    min_d = min_q;
                end
                if (count_q == CNT_SAT) begin
                    count_d = count_q;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
                state_d = last_q ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (out_ready_i) begin
                    count_d = {CNT_W{1'b0}};
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            max_q    <= {W{1'b0}};
            min_q    <= {W{1'b0}};
            sample_q <= {W{1'b0}};
            last_q   <= 1'b0;
            count_q  <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
            cmp_a_q  <= {W{1'b0}};
            cmp_b_q  <= {W{1'b0}};
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            min_q    <= min_d;
            sample_q <= sample_d;
            last_q   <= last_d;
            count_q  <= count_d;
            err_q    <= err_d;
            cmp_a_q  <= cmp_a_d;
            cmp_b_q  <= cmp_b_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign cmp_a_o     = cmp_a_q;
    assign cmp_b_o     = cmp_b_q;
    assign out_max_o   = max_q;
    assign out_min_o   = min_q;
    assign out_count_o = count_q;
    assign out_err_o   = err_q;

endmodule

// File: tb/tb_extrema_tracker.sv
// Bench for extrema_tracker: two instances (CNT_W 8 and 2) share stimulus, each with its
// own comparator model; packet results are checked against max/min/count computed directly.
module tb_extrema_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'd0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;
    logic       fault = 1'b0;

    logic       rdy0, vld0, err0, gt0, eq0, lt0;
    logic [3:0] ca0, cb0, max0, min0;
    logic [7:0] cnt0;
    logic       rdy1, vld1, err1, gt1, eq1, lt1;
    logic [3:0] ca1, cb1, max1, min1;
    logic [1:0] cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    extrema_tracker #(.W(4), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy0),
        .in_data_i(in_data), .in_last_i(in_last), .cmp_a_o(ca0), .cmp_b_o(cb0),
        .cmp_gt_i(gt0), .cmp_eq_i(eq0), .cmp_lt_i(lt0), .out_valid_o(vld0),
        .out_ready_i(out_ready), .out_max_o(max0), .out_min_o(min0),
        .out_count_o(cnt0), .out_err_o(err0));

    extrema_tracker #(.W(4), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .in_data_i(in_data), .in_last_i(in_last), .cmp_a_o(ca1), .cmp_b_o(cb1),
        .cmp_gt_i(gt1), .cmp_eq_i(eq1), .cmp_lt_i(lt1), .out_valid_o(vld1),
        .out_ready_i(out_ready), .out_max_o(max1), .out_min_o(min1),
        .out_count_o(cnt1), .out_err_o(err1));

    // Comparator models; fault forces the illegal gt=lt=1 pattern.
    always_comb begin
        gt0 = fault ? 1'b1 : (ca0 > cb0);
        eq0 = fault ? 1'b0 : (ca0 == cb0);
        lt0 = fault ? 1'b1 : (ca0 < cb0);
        gt1 = fault ? 1'b1 : (ca1 > cb1);
        eq1 = fault ? 1'b0 : (ca1 == cb1);
        lt1 = fault ? 1'b1 : (ca1 < cb1);
    end

    typedef struct {
        logic [31:0] data;
        int          len;
        int          emax;
        int          emin;
        int          ecnt;
        int          ecnt2;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic last);
        int w = 0;
        while (!rdy0 && w < 20) begin
            step();
            w++;
        end
        chk("in_ready_wait", int'(rdy0), 1);
        in_valid = 1'b1;
        in_data  = 4'(d);
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_data  = 4'(d + 5);
        in_last  = ~last;
    endtask

    task automatic chk_outs(input string nm, input int emax, input int emin,
                            input int ecnt, input int ecnt2, input int eerr);
        chk({nm, "_valid"}, int'(vld0 & vld1), 1);
        chk({nm, "_ready"}, int'(rdy0 | rdy1), 0);
        chk({nm, "_max"}, int'(max0), emax);
        chk({nm, "_min"}, int'(min0), emin);
        chk({nm, "_count"}, int'(cnt0), ecnt);
        chk({nm, "_err"}, int'(err0), eerr);
        chk({nm, "_max2"}, int'(max1), emax);
        chk({nm, "_min2"}, int'(min1), emin);
        chk({nm, "_count2"}, int'(cnt1), ecnt2);
        chk({nm, "_err2"}, int'(err1), eerr);
    endtask

    // Called one cycle after the last accept; elat is the expected cycle of out_valid.
    task automatic recv(input string nm, input int emax, input int emin, input int ecnt,
                        input int ecnt2, input int eerr, input int elat, input int hold);
        int lat = 1;
        while (!vld0 && lat < 20) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, lat, elat);
        chk_outs(nm, emax, emin, ecnt, ecnt2, eerr);
        for (int h = 0; h < hold; h++) begin
            step();
            chk_outs({nm, "_hold"}, emax, emin, ecnt, ecnt2, eerr);
        end
        out_ready = 1'b1;
        step();
        chk({nm, "_valid_drop"}, int'(vld0 | vld1), 0);
        chk({nm, "_ready_back"}, int'(rdy0 & rdy1), 1);
    endtask

    task automatic run_packet(input string nm, input int q[$], input int emax, input int emin,
                              input int ecnt, input int ecnt2, input int hold);
        out_ready = (hold == 0);
        for (int i = 0; i < q.size(); i++) send(q[i], i == q.size() - 1);
        recv(nm, emax, emin, ecnt, ecnt2, 0, (q.size() == 1) ? 1 : 3, hold);
    endtask

    task automatic run_model(input string nm, input int q[$], input int hold);
        int mx = q[0];
        int mn = q[0];
        foreach (q[i]) begin
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
        end
        run_packet(nm, q, mx, mn, (q.size() > 255) ? 255 : q.size(),
                   (q.size() > 3) ? 3 : q.size(), hold);
    endtask

    initial begin
        vec_t vecs[6];
        int   q[$];

        vecs[0] = '{32'h0000_9193, 4, 9, 1, 4, 3};
        vecs[1] = '{32'h0000_0007, 1, 7, 7, 1, 1};
        vecs[2] = '{32'h0005_4321, 5, 5, 1, 5, 3};
        vecs[3] = '{32'h0000_0F0F, 4, 15, 0, 4, 3};
        vecs[4] = '{32'h9234_5678, 8, 9, 2, 8, 3};
        vecs[5] = '{32'h0000_0000, 1, 0, 0, 1, 1};

        #3;
        chk("rst_ready", int'(rdy0 & rdy1), 1);
        chk("rst_valid", int'(vld0 | vld1), 0);
        chk("rst_outs", int'(max0) + int'(min0) + int'(cnt0) + int'(err0), 0);
        chk("rst_cmp", int'(ca0) + int'(cb0), 0);
        #9 rst_n = 1'b1;
        step();

        foreach (vecs[v]) begin
            q.delete();
            for (int i = 0; i < vecs[v].len; i++) q.push_back(int'(vecs[v].data[4*i +: 4]));
            run_packet($sformatf("vec%0d", v), q, vecs[v].emax, vecs[v].emin,
                       vecs[v].ecnt, vecs[v].ecnt2, 0);
        end

        run_packet("hold555", '{5, 5, 5}, 5, 5, 3, 3, 5);
        run_packet("after_hold", '{2}, 2, 2, 1, 1, 0);

        out_ready = 1'b1;
        send(4, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'd8;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fault_cmp_a", int'(ca0), 8);
        chk("fault_cmp_b", int'(cb0), 4);
        fault = 1'b1;
        step();
        fault = 1'b0;
        recv("fault", 8, 4, 2, 2, 1, 2, 0);
        run_packet("post_fault", '{3, 1}, 3, 1, 2, 2, 0);

        for (int r = 0; r < 20; r++) begin
            int n = $urandom_range(1, 8);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 15));
            run_model($sformatf("rand%0d", r), q, (r % 4 == 0) ? $urandom_range(1, 3) : 0);
        end

        send(3, 1'b0);
        send(9, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("amid_ready", int'(rdy0 & rdy1), 1);
        chk("amid_valid", int'(vld0 | vld1), 0);
        chk("amid_max", int'(max0), 0);
        chk("amid_count", int'(cnt0), 0);
        chk("amid_cmp", int'(ca0) + int'(cb0), 0);
        #2 rst_n = 1'b1;
        step();
        run_packet("after_rst", '{6}, 6, 6, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
